uart_tx_sequencer: RTL and testbench
====================================

# uart_tx_sequencer

- Frame sequencer for the UART transmit path.
- Accepts one byte per write strobe and serialises it onto TxD as start, 8 data bits LSB first, even parity and stop.
- Counts OVERSAMPLE pulses of the `sample_ENABLE` tick per bit period.
- Gates the baud tick generator through `baud_en`, so the tick counter runs only while a frame is in flight.
- Sits between the host-side write interface and the line driver, alongside the baud tick generator.

## Interface
- OVERSAMPLE, 16: `sample_ENABLE` pulses per bit period; power of two, 2..256.
- DATA_BITS, 8: payload bits per frame.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- Tx_EN  input  1  block enable; low aborts or blocks any frame.
- Tx_WR  input  1  write strobe, one cycle; sampled only in IDLE with Tx_EN high.
- Tx_DATA  input  DATA_BITS  byte to send; sampled on the accepted Tx_WR cycle.
- sample_ENABLE  input  1  oversample tick from the baud tick generator; one-cycle pulse.
- baud_en  output  1  enable to the baud tick generator; high exactly while Tx_BUSY is high.
- TxD  output  1  serial line; idles high.
- Tx_BUSY  output  1  high from the cycle after acceptance until frame end or abort.
- Tx_DONE  output  1  one-cycle pulse when the stop bit completes.

## Operation
- Reset values: TxD=1, Tx_BUSY=0, baud_en=0, Tx_DONE=0, state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0.
- States are IDLE, START, DATA, PARITY, STOP; all outputs are registered.
- IDLE:
  - Tx_WR & Tx_EN latches Tx_DATA into the shift register.
  - Same cycle, parity is latched as the XOR of Tx_DATA bits, giving even parity.
  - Then tick_cnt=0, bit_cnt=0, Tx_BUSY=1, baud_en=1, TxD=0, and the FSM goes to START.
- Every non-IDLE state holds its TxD value for OVERSAMPLE `sample_ENABLE` pulses.
  - tick_cnt increments on each pulse.
  - On the pulse where tick_cnt==OVERSAMPLE-1, tick_cnt wraps to 0 and the FSM advances.
- START -> DATA: TxD=shift[0].
- DATA, at each bit end:
  - If bit_cnt < DATA_BITS-1: shift right, TxD=next LSB, bit_cnt+1.
  - Else: go to PARITY with TxD=parity.
- PARITY -> STOP: TxD=1.
- STOP, at bit end:
  - Go to IDLE with TxD=1, Tx_BUSY=0, baud_en=0.
  - Tx_DONE=1 for exactly one cycle.
- Tx_WR while Tx_BUSY=1 is ignored; no queuing, and the latched data is unchanged.
- Tx_EN low in any non-IDLE state aborts on the next edge:
  - State goes to IDLE; TxD=1, Tx_BUSY=0, baud_en=0.
  - Counters clear; no Tx_DONE.
- Tx_EN low in IDLE: Tx_WR has no effect.
- A `sample_ENABLE` pulse in IDLE is ignored.
- reset asserted mid-frame returns all outputs to reset values asynchronously; deassertion leaves the FSM in IDLE.
- Counter widths: tick_cnt is log2(OVERSAMPLE) bits; bit_cnt is log2(DATA_BITS) bits.
  - Wrap is explicit compare-and-clear, never reliance on overflow.

## Timing
- Acceptance latency: Tx_WR high at edge k gives TxD=0 and Tx_BUSY=1 after edge k, so both are visible in cycle k+1.
- Frame length: (DATA_BITS+3)·OVERSAMPLE `sample_ENABLE` pulses, which is 176 with defaults.
- Each bit boundary occurs on the clk edge that samples the terminal `sample_ENABLE` pulse.
- Tx_DONE and the Tx_BUSY fall share the same edge, the end of the 176th pulse.
- A new Tx_WR is accepted in the first cycle Tx_BUSY is low, including the cycle Tx_DONE is high.
- Back-to-back frames therefore have zero idle bit time between the stop bit and the next start bit, apart from one clk cycle.
- baud_en tracks Tx_BUSY exactly, so the tick generator restarts its count at each frame start.

## Test plan
- **Reset:** reset high mid-DATA.
  - Required: TxD=1, Tx_BUSY=0, baud_en=0, Tx_DONE=0 within the same cycle, with no clk edge needed.
- **Single frame:** Tx_DATA=8'hA5, Tx_WR pulse, `sample_ENABLE` every 4 clk.
  - TxD sequence per 16 ticks: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Tx_DONE is one pulse after 176 ticks.
- **Parity odd-weight:** Tx_DATA=8'h07.
  - Parity bit=1; data bits 1,1,1,0,0,0,0,0.
- **Write while busy:** Tx_DATA=8'h3C accepted, then Tx_WR with 8'hFF mid-DATA.
  - Transmitted payload stays 8'h3C; no second frame.
- **Abort:** Tx_EN dropped at tick 40.
  - Next cycle: TxD=1, Tx_BUSY=0, baud_en=0, no Tx_DONE.
  - A subsequent write of 8'h55 sends a complete correct frame.
- **Back-to-back:** Tx_WR of 8'h81 asserted in the Tx_DONE cycle of the previous frame.
  - Start bit appears the next cycle.
  - Second frame is correct, with exactly 176 ticks.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART transmit frame sequencer
// Sends start, LSB-first data, even parity and stop, each held for OVERSAMPLE sample ticks.
module uart_tx_sequencer #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Tx_EN,
   input  logic                 Tx_WR,
   input  logic [DATA_BITS-1:0] Tx_DATA,
   input  logic                 sample_ENABLE,
   output logic                 baud_en,
   output logic                 TxD,
   output logic                 Tx_BUSY,
   output logic                 Tx_DONE
);
   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                r_state,    w_state_nxt;
   logic [TW-1:0]         r_tick_cnt, w_tick_nxt;
   logic [BW-1:0]         r_bit_cnt,  w_bit_nxt;
   logic [DATA_BITS-1:0]  r_shift,    w_shift_nxt;
   logic                  r_parity,   w_parity_nxt;
   logic                  r_txd,      w_txd_nxt;
   logic                  r_busy,     w_busy_nxt;
   logic                  r_baud_en,  w_baud_en_nxt;
   logic                  r_done,     w_done_nxt;
   logic                  w_bit_end;

   assign w_bit_end = sample_ENABLE && (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_txd      <= 1'b1;
         r_busy     <= 1'b0;
         r_baud_en  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_parity   <= w_parity_nxt;
         r_txd      <= w_txd_nxt;
         r_busy     <= w_busy_nxt;
         r_baud_en  <= w_baud_en_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_tick_nxt    = r_tick_cnt;
      w_bit_nxt     = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_parity_nxt  = r_parity;
      w_txd_nxt     = r_txd;
      w_busy_nxt    = r_busy;
      w_baud_en_nxt = r_baud_en;
      w_done_nxt    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (Tx_WR && Tx_EN) begin
               w_shift_nxt   = Tx_DATA;
               w_parity_nxt  = ^Tx_DATA;
               w_tick_nxt    = '0;
               w_bit_nxt     = '0;
               w_busy_nxt    = 1'b1;
               w_baud_en_nxt = 1'b1;
               w_txd_nxt     = 1'b0;
               w_state_nxt   = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_txd_nxt   = r_shift[0];
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_bit_cnt < BIT_LAST) begin
                  w_shift_nxt = r_shift >> 1;
                  w_txd_nxt   = r_shift[1];
                  w_bit_nxt   = r_bit_cnt + 1'b1;
               end else begin
                  w_txd_nxt   = r_parity;
                  w_state_nxt = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_txd_nxt   = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_txd_nxt     = 1'b1;
               w_busy_nxt    = 1'b0;
               w_baud_en_nxt = 1'b0;
               w_done_nxt    = 1'b1;
               w_state_nxt   = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Tick counting is shared by all in-flight states; an enable drop overrides everything.
      if (r_state != S_IDLE) begin
         if (!Tx_EN) begin
            w_state_nxt   = S_IDLE;
            w_txd_nxt     = 1'b1;
            w_busy_nxt    = 1'b0;
            w_baud_en_nxt = 1'b0;
            w_done_nxt    = 1'b0;
            w_tick_nxt    = '0;
            w_bit_nxt     = '0;
         end else if (sample_ENABLE) begin
            w_tick_nxt = w_bit_end ? '0 : r_tick_cnt + 1'b1;
         end
      end
   end

   assign TxD     = r_txd;
   assign Tx_BUSY = r_busy;
   assign baud_en = r_baud_en;
   assign Tx_DONE = r_done;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - self-checking bench for uart_tx_sequencer
// Drives inputs and samples outputs on the falling clock edge; frames are decoded like a receiver.
module tb_uart_tx_sequencer;
   localparam int OS = 16;
   localparam int NBITS = 11;
   localparam int FRAME_TICKS = NBITS * OS;

   logic       clk = 1'b0;
   logic       reset;
   logic       Tx_EN, Tx_WR, sample_ENABLE;
   logic [7:0] Tx_DATA;
   logic       baud_en, TxD, Tx_BUSY, Tx_DONE;

   int n_checks = 0;
   int n_errors = 0;
   int line_err, done_early, idle_err;
   logic [NBITS-1:0] rx_bits;
   logic [NBITS-1:0] frame;

   uart_tx_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
      .clk(clk), .reset(reset), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
      .sample_ENABLE(sample_ENABLE), .baud_en(baud_en), .TxD(TxD),
      .Tx_BUSY(Tx_BUSY), .Tx_DONE(Tx_DONE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line level for each of the eleven bit periods of a frame.
   function automatic logic [NBITS-1:0] build_frame(input logic [7:0] d);
      logic [NBITS-1:0] f;
      f[0] = 1'b0;
      for (int k = 0; k < 8; k++) f[1+k] = d[k];
      f[9]  = ($countones(d) % 2) == 1;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic accept(input string tag, input logic [7:0] d);
      Tx_DATA = d;
      Tx_WR   = 1'b1;
      @(negedge clk);
      Tx_WR   = 1'b0;
      Tx_DATA = 8'($urandom);
      chk({tag, "_accept"}, {29'd0, TxD, Tx_BUSY, baud_en}, 32'b011);
   endtask

   task automatic play(input logic [NBITS-1:0] f, input int n_ticks, input bit rnd, input int wr_at);
      int gap;
      line_err   = 0;
      done_early = 0;
      rx_bits    = '1;
      for (int t = 0; t < n_ticks; t++) begin
         gap = rnd ? int'($urandom_range(0, 3)) : 3;
         for (int g = 0; g <= gap; g++) begin
            if (TxD !== f[t/OS] || Tx_BUSY !== 1'b1 || baud_en !== 1'b1) line_err++;
            if (Tx_DONE !== 1'b0) done_early++;
            if (g == gap) begin
               if (t % OS == OS/2) rx_bits[t/OS] = TxD;
               if (t == wr_at) begin
                  Tx_WR   = 1'b1;
                  Tx_DATA = 8'hFF;
               end
               sample_ENABLE = 1'b1;
            end
            @(negedge clk);
            sample_ENABLE = 1'b0;
            Tx_WR = 1'b0;
         end
      end
   endtask

   task automatic full_frame(input string tag, input logic [7:0] d, input bit rnd,
                             input int wr_at, input bit chain);
      frame = build_frame(d);
      accept(tag, d);
      play(frame, FRAME_TICKS, rnd, wr_at);
      chk({tag, "_line"}, line_err, 0);
      chk({tag, "_done_early"}, done_early, 0);
      chk({tag, "_start"}, {31'd0, rx_bits[0]}, 0);
      chk({tag, "_payload"}, {24'd0, rx_bits[8:1]}, {24'd0, d});
      chk({tag, "_parity"}, {31'd0, rx_bits[9]}, $countones(d) % 2);
      chk({tag, "_stop"}, {31'd0, rx_bits[10]}, 1);
      chk({tag, "_end"}, {28'd0, Tx_DONE, Tx_BUSY, baud_en, TxD}, 32'b1001);
      if (!chain) begin
         @(negedge clk);
         chk({tag, "_done_1cyc"}, {31'd0, Tx_DONE}, 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      Tx_EN = 1'b1;
      Tx_WR = 1'b0;
      Tx_DATA = 8'h00;
      sample_ENABLE = 1'b0;
      @(negedge clk);
      chk("reset_state", {28'd0, Tx_DONE, Tx_BUSY, baud_en, TxD}, 32'b0001);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", {28'd0, Tx_DONE, Tx_BUSY, baud_en, TxD}, 32'b0001);

      // Idle ticks and disabled writes must leave the line untouched.
      idle_err = 0;
      for (int i = 0; i < 6; i++) begin
         sample_ENABLE = 1'b1;
         Tx_EN = (i < 3);
         Tx_WR = (i >= 3);
         Tx_DATA = 8'h5A;
         @(negedge clk);
         if (Tx_BUSY !== 1'b0 || TxD !== 1'b1 || baud_en !== 1'b0) idle_err++;
      end
      sample_ENABLE = 1'b0;
      Tx_WR = 1'b0;
      Tx_EN = 1'b1;
      @(negedge clk);
      chk("idle_ignore", idle_err, 0);

      full_frame("a5", 8'hA5, 1'b0, -1, 1'b0);
      full_frame("07", 8'h07, 1'b0, -1, 1'b0);

      full_frame("busy_wr", 8'h3C, 1'b0, 50, 1'b0);
      idle_err = 0;
      for (int i = 0; i < 20; i++) begin
         if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) idle_err++;
         @(negedge clk);
      end
      chk("no_second_frame", idle_err, 0);

      frame = build_frame(8'hC3);
      accept("abort", 8'hC3);
      play(frame, 40, 1'b0, -1);
      chk("abort_pre_line", line_err, 0);
      Tx_EN = 1'b0;
      @(negedge clk);
      chk("abort_state", {28'd0, Tx_DONE, Tx_BUSY, baud_en, TxD}, 32'b0001);
      Tx_EN = 1'b1;
      idle_err = 0;
      for (int i = 0; i < 10; i++) begin
         sample_ENABLE = (i % 2 == 0);
         @(negedge clk);
         if (Tx_DONE !== 1'b0 || Tx_BUSY !== 1'b0) idle_err++;
      end
      sample_ENABLE = 1'b0;
      chk("abort_quiet", idle_err, 0);
      full_frame("after_abort", 8'h55, 1'b0, -1, 1'b0);

      full_frame("b2b_first", 8'h6E, 1'b0, -1, 1'b1);
      full_frame("b2b_second", 8'h81, 1'b0, -1, 1'b0);

      for (int i = 0; i < 4; i++) begin
         full_frame($sformatf("rnd%0d", i), 8'($urandom), 1'b1, -1, (i == 1));
      end

      frame = build_frame(8'h9B);
      accept("mid_reset", 8'h9B);
      play(frame, 60, 1'b1, -1);
      chk("mid_reset_line", line_err, 0);
      #2 reset = 1'b1;
      #1 chk("async_reset", {28'd0, Tx_DONE, Tx_BUSY, baud_en, TxD}, 32'b0001);
      @(negedge clk);
      reset = 1'b0;
      sample_ENABLE = 1'b1;
      @(negedge clk);
      sample_ENABLE = 1'b0;
      chk("post_reset_idle", {28'd0, Tx_DONE, Tx_BUSY, baud_en, TxD}, 32'b0001);
      full_frame("post_reset", 8'h24, 1'b1, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
